systolic_skew_feeder: RTL and testbench

//  Upstream feeder for one edge (A rows or B columns) of the PE_MAC systolic array.
//  - Accepts one N-element vector per valid/ready handshake and applies the diagonal

---
 rtl/systolic_skew_feeder_pkg.sv | 17 +
 rtl/systolic_skew_feeder_delay_line.sv | 26 ++
 rtl/systolic_skew_feeder.sv | 99 +++++++++
 tb/tb_systolic_skew_feeder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared defaults, FSM state codes and helpers for the systolic array edge feeder.
package systolic_skew_feeder_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 8;
  localparam int KW_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Zero advances needed after the last vector so every lane drains through the PE pipeline.
  function automatic int flush_len(input int n);
    return n + 2;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_delay_line.sv
// Enable-gated shift register used to skew one lane of the feeder.
module skew_delay_line #(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] regs [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) regs[j] <= '0;
    end else if (en) begin
      regs[0] <= d;
      for (int j = 1; j < DEPTH; j++) regs[j] <= regs[j-1];
    end
  end

  assign q = regs[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Edge feeder for the PE_MAC systolic array: skews accepted vectors per lane and
// sequences ce/load_acc/flush so each lane's accumulator ends on an exact K-term sum.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int KW = KW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [KW-1:0]   cfg_k,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [N*DW-1:0] s_data,
  output logic [N*DW-1:0] lane_data,
  output logic            ce_out,
  output logic [N-1:0]    load_acc,
  output logic            busy,
  output logic            tile_done
);

  localparam int FLUSH_LEN = flush_len(N);

  logic [1:0]      state;
  logic [KW-1:0]   k;
  logic [KW:0]     c;
  logic [KW-1:0]   flush_cnt;
  logic            advance;
  logic            last_vec;
  logic            last_flush;
  logic [N*DW-1:0] stage_in;

  always_comb begin
    advance    = ((state == ST_FEED) && s_valid) || (state == ST_FLUSH);
    last_vec   = (c == ({1'b0, k} - 1'b1));
    last_flush = (flush_cnt == KW'(FLUSH_LEN - 1));
    stage_in   = (state == ST_FEED) ? s_data : '0;
  end

  assign s_ready = (state == ST_FEED);
  assign busy    = (state != ST_IDLE);
  assign ce_out  = advance;

  // c is the pre-increment advance index, so lane i clears on the flush-zero product it sees first.
  for (genvar i = 0; i < N; i++) begin : g_load
    assign load_acc[i] = advance && (c == (KW+1)'(i + 2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k         <= '0;
      c         <= '0;
      flush_cnt <= '0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      if (advance) c <= c + 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            k         <= cfg_k;
            c         <= '0;
            flush_cnt <= '0;
            state     <= (cfg_k != '0) ? ST_FEED : ST_FLUSH;
          end
        end
        ST_FEED: begin
          if (advance && last_vec) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (last_flush) begin
            state     <= ST_IDLE;
            tile_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Lane i carries i+1 stages, producing the diagonal skew.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(
      .DW   (DW),
      .DEPTH(i + 1)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (advance),
      .d    (stage_in[i*DW +: DW]),
      .q    (lane_data[i*DW +: DW])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench: tile-level model of the feeder plus an emulated edge PE per lane.
module tb_systolic_skew_feeder;
  import systolic_skew_feeder_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int KW = 8;
  localparam int FL = flush_len(N);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [KW-1:0]   cfg_k = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [N*DW-1:0] s_data = '0;
  logic [N*DW-1:0] lane_data;
  logic            ce_out;
  logic [N-1:0]    load_acc;
  logic            busy;
  logic            tile_done;

  systolic_skew_feeder #(.N(N), .DW(DW), .KW(KW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg_k    (cfg_k),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .lane_data(lane_data),
    .ce_out   (ce_out),
    .load_acc (load_acc),
    .busy     (busy),
    .tile_done(tile_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Tile-level model: phase 0 idle, 1 feed, 2 flush; m_adv counts advances in the tile.
  int              m_phase = 0;
  int              m_k     = 0;
  int              m_adv   = 0;
  logic            m_done  = 1'b0;
  logic [N*DW-1:0] m_vec [0:255];

  int pe_a   [N] = '{default: 0};
  int pe_p   [N] = '{default: 0};
  int pe_acc [N] = '{default: 0};
  int load_count [N] = '{default: 0};
  int ce_count = 0;

  logic [N*DW-1:0] rows_a [3];
  logic [N*DW-1:0] two_row;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {e3[DW-1:0], e2[DW-1:0], e1[DW-1:0], e0[DW-1:0]};
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_phase = 0; m_k = 0; m_adv = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        0: if (start) begin
             m_k = int'(cfg_k); m_adv = 0; m_phase = (cfg_k != '0) ? 1 : 2;
           end
        1: if (s_valid) begin
             m_vec[m_adv] = s_data; m_adv++;
             if (m_adv == m_k) m_phase = 2;
           end
        default: begin
             m_adv++;
             if (m_adv == m_k + FL) begin m_phase = 0; m_done = 1'b1; end
           end
      endcase
    end
  end

  // Vector j element i appears on lane i after advance j+i; load for lane i at advance index i+2.
  initial forever begin
    logic            exp_ce;
    logic [N-1:0]    exp_load;
    logic [N*DW-1:0] exp_lane;
    int              idx;
    @(negedge clk);
    exp_lane = '0;
    exp_load = '0;
    if (!rst_n) begin
      exp_ce = 1'b0;
      for (int i = 0; i < N; i++) begin pe_a[i] = 0; pe_p[i] = 0; pe_acc[i] = 0; end
    end else begin
      exp_ce = (m_phase == 1) ? s_valid : (m_phase == 2);
      for (int i = 0; i < N; i++) begin
        idx = m_adv - 1 - i;
        if (idx >= 0 && idx < m_k) exp_lane[i*DW +: DW] = m_vec[idx][i*DW +: DW];
        exp_load[i] = exp_ce && (m_adv == i + 2);
      end
    end
    check_output("ce_out", ce_out, exp_ce);
    check_output("s_ready", s_ready, rst_n && m_phase == 1);
    check_output("busy", busy, rst_n && m_phase != 0);
    check_output("tile_done", tile_done, rst_n && m_done);
    check_output("load_acc", load_acc, exp_load);
    for (int i = 0; i < N; i++)
      check_output($sformatf("lane_data[%0d]", i), lane_data[i*DW +: DW], exp_lane[i*DW +: DW]);
    if (rst_n && ce_out === 1'b1) begin
      ce_count++;
      for (int i = 0; i < N; i++) begin
        pe_acc[i] = (load_acc[i] ? 0 : pe_acc[i]) + pe_p[i];
        pe_p[i]   = pe_a[i];
        pe_a[i]   = int'($signed(lane_data[i*DW +: DW]));
        if (load_acc[i]) load_count[i]++;
      end
    end
  end

  task automatic begin_tile(input int k);
    start = 1'b1;
    cfg_k = k[KW-1:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic apply_stimulus(input int nvec, input bit twos, input int stall, input bit mid_start);
    for (int j = 0; j < nvec; j++) begin
      s_valid = 1'b1;
      s_data  = twos ? two_row : rows_a[j];
      if (mid_start && j == 1) begin start = 1'b1; cfg_k = 8'd7; end
      @(posedge clk); #1;
      start = 1'b0;
      if (j == 0 && stall > 0) begin
        s_valid = 1'b0;
        repeat (stall) begin @(posedge clk); #1; end
      end
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic wait_done();
    int found;
    found = 0;
    for (int n = 0; n < 60 && found == 0; n++) begin
      @(negedge clk);
      if (tile_done === 1'b1) found = 1;
    end
    #1;
    check_output("tile_done_seen", found, 1);
  endtask

  task automatic check_acc(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e [N];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < N; i++)
      check_output($sformatf("%s_acc[%0d]", tag, i), pe_acc[i], e[i]);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int base;
    int lb [N];
    int saw;
    rows_a[0] = pack4(1, 2, 3, 4);
    rows_a[1] = pack4(5, 6, 7, 8);
    rows_a[2] = pack4(-1, -1, -1, -1);
    two_row   = pack4(2, 2, 2, 2);

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_s_ready", s_ready, 1'b0);
    check_output("reset_ce_out", ce_out, 1'b0);
    check_output("reset_load_acc", load_acc, '0);
    check_output("reset_lane_data", lane_data, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] tile 1: K=3, valid held");
    base = ce_count;
    begin_tile(3);
    apply_stimulus(3, 1'b0, 0, 1'b0);
    wait_done();
    check_output("t1_advances", ce_count - base, 9);
    check_acc("t1", 5, 7, 9, 11);

    $display("[TB] tile 2: K=3, valid dropped two cycles");
    @(posedge clk); #1;
    base = ce_count;
    begin_tile(3);
    apply_stimulus(3, 1'b0, 2, 1'b0);
    wait_done();
    check_output("t2_advances", ce_count - base, 9);
    check_acc("t2", 5, 7, 9, 11);

    $display("[TB] tile 3: K=0 over stale accumulators");
    @(posedge clk); #1;
    base = ce_count;
    lb = load_count;
    begin_tile(0);
    wait_done();
    check_output("t3_advances", ce_count - base, 6);
    for (int i = 0; i < N; i++)
      check_output($sformatf("t3_loads[%0d]", i), load_count[i] - lb[i], 1);
    check_acc("t3", 0, 0, 0, 0);

    $display("[TB] tile 4: start with cfg_k=7 during feed");
    @(posedge clk); #1;
    base = ce_count;
    begin_tile(3);
    apply_stimulus(3, 1'b0, 0, 1'b1);
    wait_done();
    check_output("t4_advances", ce_count - base, 9);
    check_acc("t4", 5, 7, 9, 11);

    $display("[TB] tile 5: back-to-back start on tile_done, all twos");
    base = ce_count;
    begin_tile(3);
    apply_stimulus(3, 1'b1, 0, 1'b0);
    wait_done();
    check_output("t5_advances", ce_count - base, 9);
    check_acc("t5", 6, 6, 6, 6);

    $display("[TB] tile 6: reset at advance index 4");
    @(posedge clk); #1;
    begin_tile(3);
    apply_stimulus(3, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_output("rst_ce_out", ce_out, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_load_acc", load_acc, '0);
    check_output("rst_lane_data", lane_data, '0);
    check_output("rst_tile_done", tile_done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw = 0;
    repeat (12) begin
      @(negedge clk);
      if (tile_done !== 1'b0) saw = 1;
    end
    check_output("rst_no_tile_done", saw, 0);

    $display("[TB] tile 7: fresh tile after reset");
    @(posedge clk); #1;
    base = ce_count;
    begin_tile(3);
    apply_stimulus(3, 1'b0, 0, 1'b0);
    wait_done();
    check_output("t7_advances", ce_count - base, 9);
    check_acc("t7", 5, 7, 9, 11);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
